iou_mmio: RTL
=============

# iou_mmio

Parametrised memory-mapped I/O unit; next generation of the board I/O block. Sits between the CPU's IO bus (`io_addr`/`io_dout`/`io_din`/`io_we`/`io_rd`) and the board: LEDs, switches, buttons and the 7-segment display driver. Adds over the previous generation:
- a multi-entry switch-capture FIFO with overflow detection;
- a loadable counter with compare;
- a maskable interrupt line.

## Interface
Parameters:
- `SW_W`, 16, switch count (1..27)
- `LED_W`, 16, LED count (1..32)
- `NBTN`, 5, button count, order {C,U,L,R,D} MSB..LSB (1..5)
- `FIFO_DEPTH`, 4, capture FIFO entries, power of two, 2..16
- `SEG_BTN_MASK`, 5'b01101, button edges that set `seg_rdy`

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1, system clock
- `rstn` in 1, asynchronous active-low reset
- `sw` in SW_W, raw switches (asynchronous)
- `btn` in NBTN, raw buttons (asynchronous)
- `seg_ack` in 1, display driver done pulse
- `io_addr` in 8, byte address
- `io_dout` in 32, CPU write data
- `io_we` in 1, write strobe
- `io_rd` in 1, read strobe
- `io_din` out 32, read data (combinational from `io_addr`)
- `led` out LED_W, LED drive
- `seg_data` out 32, word to display driver
- `seg_rdy` out 1, display slot free
- `irq` out 1, interrupt, registered

## Operation
Inputs `sw` and `btn` pass a 2-FF synchroniser. Button rising edge gives a 1-cycle pulse `btn_p`.

Register map (unlisted addresses read 0, writes ignored):
- 0x00 LED: R/W. Low LED_W bits used.
- 0x04 SWT: R. `{0, btn_p, sw_sync}`.
- 0x08 SEG_RDY: R. Bit0 = `seg_rdy`.
- 0x0C SEG_DATA: R/W. A write clears `seg_rdy`.
- 0x10 SWX_CNT: R. FIFO occupancy, 0..FIFO_DEPTH.
- 0x14 SWX_DATA: R. FIFO head, or 0 if empty. `io_rd` at this address pops.
- 0x18 CNT: R/W. Free-running +1 per cycle. A write loads `io_dout`; the next cycle continues from that value.
- 0x1C CMP: R/W. Compare value.
- 0x20 CTRL: R/W. Bit0 cmp_en, bit1 auto_clr (counter reloads 0 on match).
- 0x24 STAT: R, write-1-to-clear on bits [1:0].
  - bit0 cmp_hit, sticky.
  - bit1 fifo_ovf, sticky.
  - bit2 fifo_nonempty, level, read-only.
- 0x28 MASK: R/W, bits [2:0].

FIFO push:
- Trigger: C-button edge (`btn_p[NBTN-1]`).
- Pushed value: `{0, btn_p, sw_sync}` sampled in the same cycle.

FIFO full:
- A push with no pop is dropped and sets fifo_ovf.
- A push and a pop in the same cycle on a full FIFO both proceed; occupancy unchanged, no overflow.

FIFO empty: a pop is ignored.

`seg_rdy`:
- Cleared by a write to SEG_DATA.
- Set by `seg_ack`, or by any `btn_p & SEG_BTN_MASK`.
- A SEG_DATA write in the same cycle as a set event wins (result 0).

Compare match: `cnt == cmp` with cmp_en set.
- Sets cmp_hit.
- If auto_clr, the counter becomes 0 on the next edge.
- A CPU write to CNT in the same cycle overrides the reload.

W1C vs hardware set in the same cycle: the set wins.

`irq` is registered: `irq <= |(STAT[2:0] & MASK[2:0])`.

## Timing
- Reset values:
  - LED all ones, `seg_data` 0x12345678, `seg_rdy` 1.
  - CNT 0, CMP 0xFFFFFFFF, CTRL 0, MASK 0, STAT 0.
  - FIFO empty, `irq` 0.
- Reset is asynchronous assert; all state returns to reset values immediately, including mid-FIFO-operation.
- Writes take effect on the `io_we` edge. Readback is visible the next cycle.
- `io_din` is combinational, same cycle as `io_addr`.
- A pop updates the head on the edge after the `io_rd` cycle; the data read in the `io_rd` cycle is the popped entry.
- Raw button → `btn_p`: 3 cycles (2 sync + edge).
- Button press → FIFO entry visible in SWX_CNT: 4 cycles.
- Compare match cycle N → cmp_hit set at N+1 → `irq` at N+2.
- Counter wraps 0xFFFFFFFF → 0.

## Structure
- Package `iou_pkg`: address constants (ADDR_LED…ADDR_MASK), CTRL/STAT bit indices.
- Sub-module `iou_fifo`: synchronous FIFO with parameters DEPTH and WIDTH. Ports: push, pop, full, empty, count, head.
- Synchroniser and edge detection stay inline.

## Test plan
- Reset → read 0x00 = 0x0000FFFF; 0x0C = 0x12345678; 0x08 = 1; 0x10 = 0; `irq` = 0.
- `sw`=0x00A5, press C 5× with DEPTH=4, no reads → SWX_CNT = 4, STAT bit1 = 1. Four pops each return 0x001000A5, then SWX_CNT = 0. A pop on empty returns 0.
- FIFO full, C edge in the same cycle as `io_rd` at 0x14 → count stays 4, fifo_ovf stays 0.
- Write CNT=0x10, CMP=0x20, CTRL=3, MASK=1 → cmp_hit after 16 cycles, `irq` 1 cycle later, counter restarts at 0. Writing 0x24=1 clears cmp_hit; `irq` drops the next cycle.
- Write SEG_DATA=0xDEADBEEF → `seg_rdy` 0, `seg_data` 0xDEADBEEF. An R-button edge leaves it 0; a U-button edge sets it to 1. A SEG_DATA write coincident with `seg_ack` → `seg_rdy` 0.
- Assert `rstn` low mid-stream with FIFO at 3 entries and CNT running → all registers return to reset values asynchronously.

Source files
------------

// File: rtl/iou_pkg.sv
// Shared constants for the board I/O unit: register map, CTRL/STAT bit
// positions and reset values.
`timescale 1ns/1ps
package iou_pkg;

  // Register byte addresses on the CPU IO bus.
  localparam logic [7:0] ADDR_LED      = 8'h00;
  localparam logic [7:0] ADDR_SWT      = 8'h04;
  localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
  localparam logic [7:0] ADDR_SEG_DATA = 8'h0C;
  localparam logic [7:0] ADDR_SWX_CNT  = 8'h10;
  localparam logic [7:0] ADDR_SWX_DATA = 8'h14;
  localparam logic [7:0] ADDR_CNT      = 8'h18;
  localparam logic [7:0] ADDR_CMP      = 8'h1C;
  localparam logic [7:0] ADDR_CTRL     = 8'h20;
  localparam logic [7:0] ADDR_STAT     = 8'h24;
  localparam logic [7:0] ADDR_MASK     = 8'h28;

  // CTRL bit positions.
  localparam int CTRL_CMP_EN   = 0;
  localparam int CTRL_AUTO_CLR = 1;

  // STAT bit positions (MASK uses the same layout).
  localparam int STAT_CMP_HIT  = 0;
  localparam int STAT_FIFO_OVF = 1;
  localparam int STAT_FIFO_NE  = 2;

  // Reset values.
  localparam logic [31:0] SEG_DATA_RST = 32'h1234_5678;
  localparam logic [31:0] CMP_RST      = 32'hFFFF_FFFF;

  // Compare/counter control register.
  typedef struct packed {
    logic auto_clr;
    logic cmp_en;
  } ctrl_t;

endpackage

// File: rtl/iou_mmio_if.sv
// CPU IO bus between the processor (master) and the I/O unit (slave).
`timescale 1ns/1ps
interface iou_mmio_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic [31:0] io_din;
  logic        io_we;
  logic        io_rd;

  modport master (output io_addr, output io_dout, output io_we, output io_rd, input io_din);
  modport slave  (input io_addr, input io_dout, input io_we, input io_rd, output io_din);
endinterface

// File: rtl/iou_fifo.sv
// Synchronous FIFO for switch captures. A push into a full FIFO succeeds
// only when a pop happens in the same cycle; a pop on empty is ignored.
`timescale 1ns/1ps
module iou_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage array is deliberately not reset; emptiness is defined
  // by the pointers/count, and a reset port on an array blocks RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/iou_mmio.sv
// Board I/O unit: LEDs, switches, buttons, 7-segment handshake, switch
// capture FIFO, loadable counter with compare and a maskable interrupt.
`timescale 1ns/1ps
module iou_mmio
  import iou_pkg::*;
#(
  parameter int         SW_W         = 16,
  parameter int         LED_W        = 16,
  parameter int         NBTN         = 5,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [4:0] SEG_BTN_MASK = 5'b01101
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SW_W-1:0]   sw,
  input  logic [NBTN-1:0]   btn,
  input  logic              seg_ack,
  iou_mmio_if.slave         bus,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       seg_data,
  output logic              seg_rdy,
  output logic              irq
);
  localparam int CAP_W = SW_W + NBTN;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [SW_W-1:0]  sw_s1, sw_sync;
  logic [NBTN-1:0]  btn_s1, btn_s2, btn_s3, btn_p;
  logic [CAP_W-1:0] cap;
  logic [31:0]      cnt, cmp;
  ctrl_t            ctrl;
  logic [2:0]       mask;
  logic             cmp_hit, fifo_ovf;
  logic [2:0]       stat;
  logic             we_led, we_seg, we_cnt, we_cmp, we_ctrl, we_stat, we_mask;
  logic             push, pop, match, ovf_set, seg_set;
  logic [1:0]       w1c;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CAP_W-1:0] fifo_head;
  logic [31:0]      rd_data;
  logic             dout_unused;

  // Upper write-data bits have no destination in the narrower registers.
  assign dout_unused = ^bus.io_dout;

  // Two-flop synchronisers plus a registered rising-edge pulse for buttons.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_s1   <= '0;
      sw_sync <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_s3  <= '0;
      btn_p   <= '0;
    end else begin
      sw_s1   <= sw;
      sw_sync <= sw_s1;
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      btn_p   <= btn_s2 & ~btn_s3;
    end
  end

  assign cap = {btn_p, sw_sync};

  // Write and pop strobes.
  assign we_led  = bus.io_we && (bus.io_addr == ADDR_LED);
  assign we_seg  = bus.io_we && (bus.io_addr == ADDR_SEG_DATA);
  assign we_cnt  = bus.io_we && (bus.io_addr == ADDR_CNT);
  assign we_cmp  = bus.io_we && (bus.io_addr == ADDR_CMP);
  assign we_ctrl = bus.io_we && (bus.io_addr == ADDR_CTRL);
  assign we_stat = bus.io_we && (bus.io_addr == ADDR_STAT);
  assign we_mask = bus.io_we && (bus.io_addr == ADDR_MASK);
  assign pop     = bus.io_rd && (bus.io_addr == ADDR_SWX_DATA);

  // Capture FIFO is fed by the C (MSB) button edge.
  assign push = btn_p[NBTN-1];

  iou_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CAP_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .data  (cap),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign ovf_set = push & fifo_full & ~pop;
  assign match   = ctrl.cmp_en & (cnt == cmp);
  assign seg_set = seg_ack | (|(btn_p & SEG_BTN_MASK[NBTN-1:0]));
  assign w1c     = we_stat ? bus.io_dout[1:0] : 2'b00;
  assign stat    = {~fifo_empty, fifo_ovf, cmp_hit};

  // CPU-writable configuration and display handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led      <= '1;
      seg_data <= SEG_DATA_RST;
      seg_rdy  <= 1'b1;
      cmp      <= CMP_RST;
      ctrl     <= '0;
      mask     <= '0;
    end else begin
      if (we_led)  led  <= bus.io_dout[LED_W-1:0];
      if (we_cmp)  cmp  <= bus.io_dout;
      if (we_ctrl) ctrl <= ctrl_t'(bus.io_dout[1:0]);
      if (we_mask) mask <= bus.io_dout[2:0];
      if (we_seg) begin
        seg_data <= bus.io_dout;
        seg_rdy  <= 1'b0;
      end else if (seg_set) begin
        seg_rdy  <= 1'b1;
      end
    end
  end

  // Free-running counter; a CPU load beats the compare auto-reload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (we_cnt) begin
      cnt <= bus.io_dout;
    end else if (match && ctrl.auto_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Sticky status flags (hardware set beats W1C) and registered interrupt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_hit  <= 1'b0;
      fifo_ovf <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cmp_hit  <= (cmp_hit  & ~w1c[STAT_CMP_HIT])  | match;
      fifo_ovf <= (fifo_ovf & ~w1c[STAT_FIFO_OVF]) | ovf_set;
      irq      <= |(stat & mask);
    end
  end

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // rd_data unassigned, which would otherwise infer a latch.
    rd_data = '0;
    case (bus.io_addr)
      ADDR_LED:      rd_data[LED_W-1:0] = led;
      ADDR_SWT:      rd_data[CAP_W-1:0] = cap;
      ADDR_SEG_RDY:  rd_data[0]         = seg_rdy;
      ADDR_SEG_DATA: rd_data            = seg_data;
      ADDR_SWX_CNT:  rd_data[CW-1:0]    = fifo_count;
      ADDR_SWX_DATA: if (!fifo_empty) rd_data[CAP_W-1:0] = fifo_head;
      ADDR_CNT:      rd_data            = cnt;
      ADDR_CMP:      rd_data            = cmp;
      ADDR_CTRL:     rd_data[1:0]       = ctrl;
      ADDR_STAT:     rd_data[2:0]       = stat;
      ADDR_MASK:     rd_data[2:0]       = mask;
      default:       rd_data            = '0;
    endcase
  end

  assign bus.io_din = rd_data;

endmodule
